// File: rtl/fir_interp_tx.sv
// 4x interpolating polyphase FIR for the TX chain: one serial MAC walks an
// 8-tap branch per output phase, giving 4 outputs per accepted input sample.
module fir_interp_tx #(
  parameter int DW  = 12,
  parameter int L   = 4,
  parameter int TPP = 8,
  parameter int CW  = 8
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int AW = DW + CW + 3;
  localparam int PW = L*TPP;
  localparam int NT = L * TPP;
  localparam int JW = $clog2(TPP);
  localparam int LW = $clog2(L);
  localparam int SH = 8;
  localparam logic [JW-1:0] J_LAST = JW'(TPP - 1);
  localparam logic [LW-1:0] P_LAST = LW'(L - 1);
  localparam logic signed [AW-1:0] RND = AW'(1) <<< (SH - 1);

  // Branch p holds h[p], h[p+4], ... ; each branch sums to 256.
  localparam logic signed [CW-1:0] H [NT] = '{
    8'sd3,  8'sd5,  8'sd7,  8'sd9,  8'sd11, 8'sd15, 8'sd19, 8'sd23,
    8'sd29, 8'sd35, 8'sd41, 8'sd47, 8'sd55, 8'sd63, 8'sd71, 8'sd79,
    8'sd79, 8'sd71, 8'sd63, 8'sd55, 8'sd47, 8'sd41, 8'sd35, 8'sd29,
    8'sd23, 8'sd19, 8'sd15, 8'sd11, 8'sd9,  8'sd7,  8'sd5,  8'sd3
  };

  typedef enum logic [1:0] {ACCEPT, MAC, OUT} state_t;

  state_t                   state, state_nxt;
  logic signed [DW-1:0]     x [TPP];
  logic signed [AW-1:0]     acc;
  logic [LW-1:0]            p;
  logic [JW-1:0]            j;
  logic [$clog2(NT)-1:0]    tap_idx;
  logic signed [DW+CW-1:0]  x_ext, h_ext, prod;
  logic signed [AW-1:0]     acc_sum, acc_shr;
  logic                     in_hs;

  assign in_hs     = in_valid & in_ready;
  assign out_valid = (state == OUT);

  // Coefficient index p + L*j; L and TPP are powers of two.
  assign tap_idx = {j, p};
  assign x_ext   = (DW+CW)'(x[j]);
  assign h_ext   = (DW+CW)'(H[tap_idx]);
  assign prod    = x_ext * h_ext;
  assign acc_sum = acc + AW'(prod);
  assign acc_shr = (acc_sum + RND) >>> SH;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ACCEPT;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ACCEPT: if (in_hs)        state_nxt = MAC;
      MAC:    if (j == J_LAST)  state_nxt = OUT;
      OUT:    if (out_ready)    state_nxt = (p == P_LAST) ? ACCEPT : MAC;
      default:                  state_nxt = ACCEPT;
    endcase
  end

  // NOTE: the delay line is reset like any register so a reset mid-stream
  // restarts from silence rather than replaying stale history.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int k = 0; k < TPP; k++) x[k] <= '0;
      acc      <= '0;
      p        <= '0;
      j        <= '0;
      out_data <= '0;
      in_ready <= 1'b0;
    end else begin
      // Registered so in_ready stays low while RSTn is asserted.
      in_ready <= (state_nxt == ACCEPT);
      case (state)
        ACCEPT: begin
          if (in_hs) begin
            x[0] <= in_data;
            for (int k = 1; k < TPP; k++) x[k] <= x[k-1];
            p   <= '0;
            j   <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          j   <= j + JW'(1);
          if (j == J_LAST) out_data <= acc_shr[DW-1:0];
        end
        OUT: begin
          if (out_ready && (p != P_LAST)) begin
            p   <= p + LW'(1);
            j   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp_tx.sv
// Scoreboard bench for fir_interp_tx: a bench-side delay-line model queues the
// four expected outputs of each accepted sample; outputs are popped and compared.
module tb_fir_interp_tx;

  logic               CLK = 1'b0;
  logic               RSTn = 1'b0;
  logic signed [11:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int H [32] = '{3, 5, 7, 9, 11, 15, 19, 23, 29, 35, 41, 47, 55, 63, 71, 79,
                 79, 71, 63, 55, 47, 41, 35, 29, 23, 19, 15, 11, 9, 7, 5, 3};
  int                 mx [8];
  logic signed [11:0] sb [$];
  logic signed [11:0] got [4];
  bit                 got_to;

  fir_interp_tx dut (
    .CLK(CLK), .RSTn(RSTn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_push(input int v);
    int sum;
    for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = v;
    for (int ph = 0; ph < 4; ph++) begin
      sum = 0;
      for (int k = 0; k < 8; k++) sum += mx[k] * H[ph + 4*k];
      sb.push_back(12'((sum + 128) >>> 8));
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) mx[k] = 0;
    sb.delete();
  endtask

  task automatic send_sample(input int v, output bit to);
    to = 1'b1;
    in_data  = 12'(v);
    in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (in_ready) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    if (!to) begin
      model_push(v);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic take_output(output logic signed [11:0] d, output bit to);
    to = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    d = out_data;
    if (!to) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic run_sample(input int v);
    bit to;
    got_to = 1'b0;
    send_sample(v, to);
    got_to |= to;
    for (int q = 0; q < 4; q++) begin
      take_output(got[q], to);
      got_to |= to;
    end
  endtask

  task automatic test_reset_start();
    RSTn = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 12'sd0) begin
      n_fail++;
      $display("FAIL reset_start: in_ready=%b out_valid=%b out_data=%0d, want 0 0 0",
               in_ready, out_valid, out_data);
    end
    RSTn = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
    end
    model_clear();
  endtask

  task automatic test_impulse();
    logic signed [11:0] outs [40];
    logic signed [11:0] e;
    int first8 [8] = '{12, 20, 27, 35, 43, 59, 74, 90};
    for (int s = 0; s < 10; s++) begin
      run_sample(s == 0 ? 1000 : 0);
      n_checks++;
      if (got_to) begin
        n_fail++;
        $display("FAIL impulse_timeout: sample %0d got no handshake in budget", s);
        sb.delete();
        return;
      end
      for (int q = 0; q < 4; q++) begin
        outs[4*s+q] = got[q];
        e = sb.pop_front();
        n_checks++;
        if (got[q] !== e) begin
          n_fail++;
          $display("FAIL impulse_sb[%0d]: got %0d, want %0d", 4*s+q, got[q], e);
        end
      end
    end
    for (int i = 0; i < 40; i++) begin
      if (i < 8 || i >= 31) begin
        e = (i < 8) ? 12'(first8[i]) : (i == 31 ? 12'sd12 : 12'sd0);
        n_checks++;
        if (outs[i] !== e) begin
          n_fail++;
          $display("FAIL impulse_const[%0d]: got %0d, want %0d", i, outs[i], e);
        end
      end
    end
  endtask

  task automatic test_dc(input int v, input int n, input string tag);
    logic signed [11:0] e;
    for (int s = 0; s < n; s++) begin
      run_sample(v);
      n_checks++;
      if (got_to) begin
        n_fail++;
        $display("FAIL %s_timeout: sample %0d", tag, s);
        sb.delete();
        return;
      end
      for (int q = 0; q < 4; q++) begin
        e = sb.pop_front();
        n_checks++;
        if (got[q] !== e) begin
          n_fail++;
          $display("FAIL %s_sb[%0d.%0d]: got %0d, want %0d", tag, s, q, got[q], e);
        end
        if (s >= 7) begin
          n_checks++;
          if (got[q] !== 12'(v)) begin
            n_fail++;
            $display("FAIL %s_settled[%0d.%0d]: got %0d, want %0d", tag, s, q, got[q], v);
          end
        end
      end
    end
  endtask

  task automatic test_fullscale();
    test_dc(2047, 10, "fs_pos");
    test_dc(-2048, 10, "fs_neg");
    test_dc(2047, 10, "fs_pos2");
  endtask

  task automatic test_backpressure();
    logic signed [11:0] d, d0, e;
    bit to;
    for (int s = 0; s < 8; s++) begin
      send_sample(int'($urandom_range(0, 4095)) - 2048, to);
      for (int q = 0; q < 4; q++) begin
        take_output(d, to);
        if (s == 7 && q == 0) break;
        n_checks++;
        if (to) begin
          n_fail++;
          $display("FAIL bp_timeout: sample %0d phase %0d", s, q);
          sb.delete();
          return;
        end
        e = sb.pop_front();
        n_checks++;
        if (d !== e) begin
          n_fail++;
          $display("FAIL bp_sb[%0d.%0d]: got %0d, want %0d", s, q, d, e);
        end
      end
    end
    // Phase 0 of the last sample was just taken; compare it, then stall phase 1.
    e = sb.pop_front();
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL bp_p0: got %0d, want %0d", d, e);
    end
    for (int c = 0; c < 60 && !out_valid; c++) tick();
    d0 = out_data;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== d0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: out_valid=%b out_data=%0d in_ready=%b, want 1 %0d 0",
                 c, out_valid, out_data, in_ready, d0);
      end
    end
    for (int q = 1; q < 4; q++) begin
      take_output(d, to);
      e = sb.pop_front();
      n_checks++;
      if (to || d !== e) begin
        n_fail++;
        $display("FAIL bp_after[%0d]: got %0d timeout=%0b, want %0d", q, d, to, e);
      end
    end
  endtask

  task automatic test_reset_midop();
    bit to;
    run_sample(500);
    run_sample(-300);
    run_sample(700);
    sb.delete();
    send_sample(900, to);
    repeat (3) tick();
    #2 RSTn = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 12'sd0) begin
      n_fail++;
      $display("FAIL reset_midop: in_ready=%b out_valid=%b out_data=%0d, want 0 0 0",
               in_ready, out_valid, out_data);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
    end
    RSTn = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop_release: in_ready=%b out_valid=%b, want 1 0",
               in_ready, out_valid);
    end
    model_clear();
  endtask

  task automatic test_back_to_back();
    logic signed [11:0] e;
    int last_acc = 0, outs_since = 0, n_acc = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 12'(int'($urandom_range(0, 4095)) - 2048);
    for (int c = 0; c < 153; c++) begin
      if (in_ready) begin
        if (n_acc > 0) begin
          n_checks++;
          if (c - last_acc != 37 || outs_since != 4) begin
            n_fail++;
            $display("FAIL b2b_period: period %0d outputs %0d, want 37 4",
                     c - last_acc, outs_since);
          end
        end
        last_acc = c;
        outs_since = 0;
        n_acc++;
        model_push(int'(in_data));
      end
      if (out_valid) begin
        if (outs_since == 0) begin
          n_checks++;
          if (c - last_acc != 9) begin
            n_fail++;
            $display("FAIL b2b_latency: first out_valid after %0d cycles, want 9", c - last_acc);
          end
        end
        e = (sb.size() > 0) ? sb.pop_front() : 12'sd0;
        n_checks++;
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL b2b_sb: got %0d, want %0d", out_data, e);
        end
        outs_since++;
      end
      tick();
      in_data = 12'(int'($urandom_range(0, 4095)) - 2048);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      if (out_valid) begin
        e = sb.pop_front();
        n_checks++;
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL b2b_drain: got %0d, want %0d", out_data, e);
        end
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (n_acc < 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: accepted %0d leftover %0d, want >=4 0", n_acc, sb.size());
    end
  endtask

  initial begin
    model_clear();
    test_reset_start();
    test_impulse();
    test_dc(1000, 12, "dc");
    test_fullscale();
    test_backpressure();
    test_reset_midop();
    test_impulse();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
